// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
//
// Purpose: groups the fetch-side and execute-side handshake/data signals of
// the decode stage into one bundle.
//
// Signal summary:
//   Fetch side    : in_valid, in_ready, in_inst[31:0], in_pc[31:0], flush
//   Execute side  : out_valid, out_ready
//   Decoded data  : out_alu_op[3:0], out_flag, out_eq, out_imm[31:0],
//                   out_rs1/out_rs2/out_rd[4:0], out_pc[31:0]
//   Control flags : out_use_imm, out_use_pc, out_is_branch, out_is_jump,
//                   out_is_load, out_is_store, out_reg_write, out_illegal
//
// Modports:
//   slave  - the decode stage itself
//   master - the surrounding fetch/execute environment
// ---------------------------------------------------------------------------
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic        out_flag;
    logic        out_eq;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        out_use_imm;
    logic        out_use_pc;
    logic        out_is_branch;
    logic        out_is_jump;
    logic        out_is_load;
    logic        out_is_store;
    logic        out_reg_write;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_alu_op, out_flag, out_eq, out_imm,
               out_rs1, out_rs2, out_rd, out_pc, out_use_imm, out_use_pc,
               out_is_branch, out_is_jump, out_is_load, out_is_store,
               out_reg_write, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_alu_op, out_flag, out_eq, out_imm,
               out_rs1, out_rs2, out_rd, out_pc, out_use_imm, out_use_pc,
               out_is_branch, out_is_jump, out_is_load, out_is_store,
               out_reg_write, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Purpose: RV32IM instruction decoder with a two-entry (main + skid) output
// buffer. Instructions are decoded combinationally on the way in and the
// decoded fields are stored, so a decoded instruction appears on the outputs
// one cycle after it is accepted.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - decode_stage_if.slave: fetch-side handshake (in_*, flush),
//          execute-side handshake (out_valid/out_ready) and decoded fields
// ---------------------------------------------------------------------------
module decode_stage (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [3:0]  aluOp;
        logic        flag;
        logic        eq;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        useImm;
        logic        usePc;
        logic        isBranch;
        logic        isJump;
        logic        isLoad;
        logic        isStore;
        logic        regWrite;
        logic        illegal;
    } decoded_t;

    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immU;
    logic [31:0] w_immJ;
    decoded_t    w_dec;
    logic        w_accept;
    logic        w_consume;

    decoded_t    r_main;
    decoded_t    r_skid;
    logic        r_mainValid;
    logic        r_skidValid;

    // Raw instruction fields and the five immediate formats, all
    // sign-extended from bit 31; B and J are halfword offsets so bit 0 is 0.
    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];
    assign w_funct3 = w_inst[14:12];
    assign w_funct7 = w_inst[31:25];
    assign w_immI   = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_immS   = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_immB   = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                       w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_immU   = {w_inst[31:12], 12'b0};
    assign w_immJ   = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                       w_inst[20], w_inst[30:21], 1'b0};

    // Combinational decode of the incoming word. Everything starts cleared,
    // each opcode fills in what it needs, and a final pass strips register
    // writes to x0 and all unit-select flags from illegal encodings so they
    // flow downstream as harmless bubbles carrying the illegal bit.
    always_comb begin
        w_dec     = '0;
        w_dec.rs1 = w_inst[19:15];
        w_dec.rs2 = w_inst[24:20];
        w_dec.rd  = w_inst[11:7];
        w_dec.pc  = bus.in_pc;
        if (w_inst[1:0] != 2'b11) begin
            w_dec.illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_OP: begin
                    w_dec.aluOp    = {w_inst[25], w_funct3};
                    w_dec.regWrite = 1'b1;
                    if (w_funct7 == 7'b0100000) begin
                        if (w_funct3 == 3'b000 || w_funct3 == 3'b101) begin
                            w_dec.flag = 1'b1;
                        end else begin
                            w_dec.illegal = 1'b1;
                        end
                    end else if (w_funct7 != 7'b0000000 &&
                                 w_funct7 != 7'b0000001) begin
                        w_dec.illegal = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    w_dec.aluOp    = {1'b0, w_funct3};
                    w_dec.useImm   = 1'b1;
                    w_dec.imm      = w_immI;
                    w_dec.regWrite = 1'b1;
                    if (w_funct3 == 3'b101) begin
                        w_dec.flag = w_inst[30];
                        if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) begin
                            w_dec.illegal = 1'b1;
                        end
                    end else if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000) begin
                        w_dec.illegal = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    w_dec.aluOp    = {2'b00, w_inst[14:13]};
                    w_dec.flag     = (w_inst[14:13] == 2'b00);
                    w_dec.eq       = ~(w_inst[14] ^ w_inst[12]);
                    w_dec.imm      = w_immB;
                    w_dec.isBranch = 1'b1;
                    if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
                        w_dec.illegal = 1'b1;
                    end
                end
                OPC_LOAD: begin
                    w_dec.imm      = w_immI;
                    w_dec.useImm   = 1'b1;
                    w_dec.isLoad   = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                OPC_STORE: begin
                    w_dec.imm     = w_immS;
                    w_dec.useImm  = 1'b1;
                    w_dec.isStore = 1'b1;
                end
                OPC_JAL: begin
                    w_dec.imm      = w_immJ;
                    w_dec.usePc    = 1'b1;
                    w_dec.isJump   = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                OPC_JALR: begin
                    w_dec.imm      = w_immI;
                    w_dec.useImm   = 1'b1;
                    w_dec.isJump   = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                OPC_LUI: begin
                    w_dec.imm      = w_immU;
                    w_dec.rs1      = 5'd0;
                    w_dec.useImm   = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                OPC_AUIPC: begin
                    w_dec.imm      = w_immU;
                    w_dec.rs1      = 5'd0;
                    w_dec.useImm   = 1'b1;
                    w_dec.usePc    = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                default: begin
                    w_dec.illegal = 1'b1;
                end
            endcase
        end
        if (w_dec.illegal || w_dec.rd == 5'd0) begin
            w_dec.regWrite = 1'b0;
        end
        if (w_dec.illegal) begin
            w_dec.isBranch = 1'b0;
            w_dec.isJump   = 1'b0;
            w_dec.isLoad   = 1'b0;
            w_dec.isStore  = 1'b0;
        end
    end

    // Handshake qualifiers. Readiness depends only on the skid register, so
    // the fetch side never sees a combinational path from out_ready.
    assign w_accept  = bus.in_valid & ~r_skidValid;
    assign w_consume = r_mainValid & bus.out_ready;

    // Main/skid buffer. Priority: reset, then flush (which also drops any
    // simultaneous acceptance), then skid-to-main refill on consume, then a
    // new acceptance going into main if it is free or draining, else skid.
    // When skid is full in_ready is low, so refill and accept never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (bus.flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_consume && r_skidValid) begin
            r_main      <= r_skid;
            r_skidValid <= 1'b0;
        end else if (w_accept) begin
            if (!r_mainValid || w_consume) begin
                r_main      <= w_dec;
                r_mainValid <= 1'b1;
            end else begin
                r_skid      <= w_dec;
                r_skidValid <= 1'b1;
            end
        end else if (w_consume) begin
            r_mainValid <= 1'b0;
        end
    end

    // The main entry drives the execute side directly.
    assign bus.in_ready      = ~r_skidValid;
    assign bus.out_valid     = r_mainValid;
    assign bus.out_alu_op    = r_main.aluOp;
    assign bus.out_flag      = r_main.flag;
    assign bus.out_eq        = r_main.eq;
    assign bus.out_imm       = r_main.imm;
    assign bus.out_rs1       = r_main.rs1;
    assign bus.out_rs2       = r_main.rs2;
    assign bus.out_rd        = r_main.rd;
    assign bus.out_pc        = r_main.pc;
    assign bus.out_use_imm   = r_main.useImm;
    assign bus.out_use_pc    = r_main.usePc;
    assign bus.out_is_branch = r_main.isBranch;
    assign bus.out_is_jump   = r_main.isJump;
    assign bus.out_is_load   = r_main.isLoad;
    assign bus.out_is_store  = r_main.isStore;
    assign bus.out_reg_write = r_main.regWrite;
    assign bus.out_illegal   = r_main.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have in_valid (input, 1) / in_ready (output, 1): fetch-side handshake; a transfer occurs when both are 1 at a clock edge.
REQ-004 SHALL have in_inst (input, 32) and in_pc (input, 32): instruction word and its address.
REQ-005 SHALL have flush (input, 1): discard all held instructions.
REQ-006 SHALL have out_valid (output, 1) / out_ready (input, 1): execute-side handshake.
REQ-007 SHALL have out_alu_op (output, 4), out_flag (output, 1) and out_eq (output, 1): ALU opcode, sub/arith-shift flag and branch-sense bit.
REQ-008 SHALL have out_imm (output, 32): sign-extended immediate.
REQ-009 SHALL have out_rs1, out_rs2 and out_rd (outputs, 5 each): register indices.
REQ-010 SHALL have out_pc (output, 32): PC of the held instruction.
REQ-011 SHALL have out_use_imm, out_use_pc, out_is_branch, out_is_jump, out_is_load, out_is_store, out_reg_write and out_illegal (outputs, 1 each): control flags.

Function
REQ-012 SHALL hold two entries: main (drives out_*) and skid; out_valid = main valid; in_ready = NOT skid valid, taken directly from a register.
REQ-013 SHALL write an accepted instruction into main when main is empty or being consumed (out_valid AND out_ready) with skid empty; otherwise SHALL write it into skid.
REQ-014 SHALL, on consume with skid full, move skid into main that edge and clear skid.
REQ-015 SHALL decode combinationally before capture; entries store decoded fields, giving a latency of 1 cycle from acceptance to out_valid.
REQ-016 SHALL decode OP (0110011): alu_op = {inst[25], inst[14:12]}; flag = 1 only for SUB (funct7 0100000, funct3 000) and SRA (funct7 0100000, funct3 101).
REQ-017 SHALL treat these OP funct7 values as legal: 0000000, 0000001, and 0100000 with funct3 000 or 101 only; any other SHALL set illegal.
REQ-018 SHALL decode OP-IMM (0010011): alu_op = {0, inst[14:12]}; use_imm = 1; flag = inst[30] only when funct3 = 101.
REQ-019 SHALL set illegal for shift-immediates whose inst[31:25] is not 0000000 or 0100000 (0100000 only for funct3 101).
REQ-020 SHALL decode BRANCH (1100011): alu_op = {00, inst[14:13]}; flag = 1 when inst[14:13] = 00; eq = NOT(inst[14] XOR inst[12]); is_branch = 1; reg_write = 0.
REQ-021 SHALL set illegal for BRANCH funct3 010 and 011.
REQ-022 SHALL decode LOAD, STORE, JAL, JALR, AUIPC and LUI with alu_op 0000 and flag 0.
REQ-023 SHALL force out_rs1 = 0 for LUI and AUIPC, and SHALL set use_pc = 1 for AUIPC and JAL.
REQ-024 SHALL set eq = 0 for every non-branch.
REQ-025 SHALL build immediates by format: I, S, B (bit0 = 0), U (low 12 bits = 0) and J (bit0 = 0), each sign-extended from inst[31].
REQ-026 SHALL set reg_write = 1 only for legal OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC.
REQ-027 SHALL set reg_write = 0 whenever rd = 0.
REQ-028 SHALL treat an unknown opcode, or inst[1:0] != 11, as illegal: illegal = 1, reg_write = 0, is_* = 0; the instruction still passes downstream.
REQ-029 SHALL, on flush, clear main and skid valid at that edge; flush SHALL override a simultaneous acceptance, which is dropped.
REQ-030 SHALL keep out_* stable while out_valid = 1 and out_ready = 0.

Reset
REQ-031 SHALL, while rst = 1, asynchronously clear main and skid valid, so out_valid = 0 and in_ready = 1.
REQ-032 SHALL force all out_* data fields to 0 while rst = 1.
REQ-033 SHALL discard any in-flight handshake when rst asserts mid-operation.
REQ-034 SHALL accept input on the first clock edge after rst deasserts.

Verification
REQ-035 SHALL test SUB: in_inst 0x40208033 -> next cycle out_valid = 1, alu_op 0000, flag 1, rs1 1, rs2 2, rd 0, reg_write 0.
REQ-036 SHALL test BGE: in_inst 0x0020D463 -> alu_op 0010, flag 0, eq 1, imm 8, is_branch 1.
REQ-037 SHALL test DIVU/SRAI: 0x0220D0B3 -> alu_op 1101; 0x4030D093 -> alu_op 0101, flag 1, use_imm 1, imm 0x403.
REQ-038 SHALL test backpressure: out_ready held 0 with 3 offers -> two accepted, in_ready = 0 after the 2nd, out_* unchanged; out_ready = 1 -> in order, no loss.
REQ-039 SHALL test flush with in_valid = 1 and both entries full -> next cycle out_valid = 0, in_ready = 1, offered instruction not emitted.
REQ-040 SHALL test illegal input: 0xFFFFFFFF -> out_illegal 1, reg_write 0; rst pulsed mid-stream -> out_valid 0 immediately.
